elev_request_queue: RTL and testbench

- Upstream stage of the elevator controller (elev_ctrl). Captures raw cabin and hall button inputs and keeps them as pending requests until they are served.
- Synchronises each button, detects its rising edge, and holds the request in a per-floor, per-type pending register.
- Clears pending requests when the car stands at the floor with the door open, using a direction-aware (collective) rule.
- Presents the merged request vector plus above/below/here summaries that elev_ctrl uses for its direction decisions.

---
 rtl/elev_pkg.sv | 39 +++
 rtl/elev_request_queue_if.sv | 41 ++++
 rtl/elev_btn_sync.sv | 36 +++
 rtl/elev_request_queue.sv | 115 +++++++++++
 tb/tb_elev_request_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator request path.
//   dir_t       : last travel direction seen by the request queue
//   N_FLOORS    : default floor count
//   FLOOR_W     : default floor index width
//   above_mask  : floors strictly above a given floor (below_mask derived)
package elev_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam int N_FLOORS   = 10;
  localparam int FLOOR_W    = 4;
  // Masks are built at a fixed wide width so any floor count up to this fits;
  // callers keep the low n bits.
  localparam int MAX_FLOORS = 32;

  function automatic logic [MAX_FLOORS-1:0] above_mask(input int unsigned fl,
                                                       input int unsigned n = N_FLOORS);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++)
      m[i] = (i > fl) && (i < n);
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] below_mask(input int unsigned fl,
                                                       input int unsigned n = N_FLOORS);
    logic [MAX_FLOORS-1:0] valid;
    valid = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++)
      valid[i] = (i < n);
    // Everything valid that is neither above nor the floor itself.
    return valid & ~above_mask(fl, n) & ~({{(MAX_FLOORS-1){1'b0}}, 1'b1} << fl);
  endfunction

endpackage

// File: rtl/elev_request_queue_if.sv
// Button / position / pending-request bundle between the button panel side
// (master) and elev_request_queue (slave).
//   buttons_*        : raw cabin and hall buttons
//   floor, open_door : car position and door state from elev_ctrl
//   up/down_signal   : car motion from elev_ctrl
//   pend_*, requests : pending requests and their per-floor merge
//   req_above/below/here, new_req : summaries for elev_ctrl
interface elev_request_queue_if #(
  parameter int N_FLOORS = elev_pkg::N_FLOORS,
  parameter int FLOOR_W  = elev_pkg::FLOOR_W
);
  logic [N_FLOORS-1:0] buttons_inside;
  logic [N_FLOORS-2:0] buttons_outside_up;
  logic [N_FLOORS-1:1] buttons_outside_down;
  logic [FLOOR_W-1:0]  floor;
  logic                open_door;
  logic                up_signal;
  logic                down_signal;
  logic [N_FLOORS-1:0] pend_in;
  logic [N_FLOORS-2:0] pend_up;
  logic [N_FLOORS-1:1] pend_down;
  logic [N_FLOORS-1:0] requests;
  logic                req_above;
  logic                req_below;
  logic                req_here;
  logic                new_req;

  modport master (
    output buttons_inside, buttons_outside_up, buttons_outside_down,
           floor, open_door, up_signal, down_signal,
    input  pend_in, pend_up, pend_down, requests,
           req_above, req_below, req_here, new_req
  );

  modport slave (
    input  buttons_inside, buttons_outside_up, buttons_outside_down,
           floor, open_door, up_signal, down_signal,
    output pend_in, pend_up, pend_down, requests,
           req_above, req_below, req_here, new_req
  );
endinterface

// File: rtl/elev_btn_sync.sv
// Button synchroniser plus rising-edge pulse.
//   clock, reset : system clock, async active-high reset
//   btn          : raw asynchronous buttons
//   rise         : one-cycle pulse per synchronised 0->1 transition
// Edges are suppressed until the chain has refilled after reset, so a button
// held across reset release never produces a pulse.
module elev_btn_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [SYNC_STAGES:0]              vld_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q   <= sync_q[SYNC_STAGES-1];
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // prev_q only tracks real samples once SYNC_STAGES+1 edges have passed.
  assign rise = vld_pipe[SYNC_STAGES] ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;

endmodule

// File: rtl/elev_request_queue.sv
// Pending request store for the elevator controller.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : buttons and car state in; pending vectors, merged
//                  requests, above/below/here summaries and new_req out
// Buttons set pending bits on their synchronised rising edge; an open door
// clears them with a collective rule that keeps the hall call for the
// opposite direction while requests remain ahead of the car.
module elev_request_queue #(
  parameter int N_FLOORS    = elev_pkg::N_FLOORS,
  parameter int FLOOR_W     = elev_pkg::FLOOR_W,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clock,
  input logic                 reset,
  elev_request_queue_if.slave bus
);
  import elev_pkg::*;

  logic [N_FLOORS-1:0] in_rise;
  logic [N_FLOORS-2:0] up_rise;
  logic [N_FLOORS-1:1] dn_rise;

  elev_btn_sync #(.WIDTH(N_FLOORS), .SYNC_STAGES(SYNC_STAGES)) u_sync_in (
    .clock(clock), .reset(reset), .btn(bus.buttons_inside), .rise(in_rise));
  elev_btn_sync #(.WIDTH(N_FLOORS-1), .SYNC_STAGES(SYNC_STAGES)) u_sync_up (
    .clock(clock), .reset(reset), .btn(bus.buttons_outside_up), .rise(up_rise));
  elev_btn_sync #(.WIDTH(N_FLOORS-1), .SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
    .clock(clock), .reset(reset), .btn(bus.buttons_outside_down), .rise(dn_rise));

  dir_t                last_dir, last_dir_n;
  logic [N_FLOORS-1:0] pend_in_q;
  logic [N_FLOORS-2:0] pend_up_q;
  logic [N_FLOORS-1:1] pend_dn_q;
  logic                new_req_q;

  // Merged per-floor view; missing hall bits at the ends contribute 0.
  logic [N_FLOORS-1:0] req;
  always_comb begin
    req                = pend_in_q;
    req[N_FLOORS-2:0]  = req[N_FLOORS-2:0] | pend_up_q;
    req[N_FLOORS-1:1]  = req[N_FLOORS-1:1] | pend_dn_q;
  end

  logic               in_range;
  logic [FLOOR_W-1:0] floor_sat;
  assign in_range  = int'(bus.floor) < N_FLOORS;
  assign floor_sat = in_range ? bus.floor : FLOOR_W'(N_FLOORS-1);

  logic [MAX_FLOORS-1:0] above_full, below_full;
  logic                  has_above, has_below;
  logic                  unused_mask_hi;
  assign above_full     = above_mask(32'(floor_sat), N_FLOORS);
  assign below_full     = below_mask(32'(floor_sat), N_FLOORS);
  assign has_above      = |(req & above_full[N_FLOORS-1:0]);
  assign has_below      = |(req & below_full[N_FLOORS-1:0]);
  assign unused_mask_hi = ^{above_full[MAX_FLOORS-1:N_FLOORS], below_full[MAX_FLOORS-1:N_FLOORS]};

  // Clear masks: fhot marks the served floor only while the door is open there.
  logic [N_FLOORS-1:0] fhot;
  logic                up_clr_en, dn_clr_en;
  logic [N_FLOORS-2:0] clr_up;
  logic [N_FLOORS-1:1] clr_dn;

  assign fhot = (bus.open_door && in_range) ?
                ({{(N_FLOORS-1){1'b0}}, 1'b1} << bus.floor) : '0;

  always_comb begin
    up_clr_en = 1'b1;
    dn_clr_en = 1'b1;
    case (last_dir)
      DIR_UP:   dn_clr_en = ~has_above;  // keep the down call while work remains above
      DIR_DOWN: up_clr_en = ~has_below;  // keep the up call while work remains below
      default: ;
    endcase
  end

  assign clr_up = up_clr_en ? fhot[N_FLOORS-2:0] : '0;
  assign clr_dn = dn_clr_en ? fhot[N_FLOORS-1:1] : '0;

  // Both motion bits at once is illegal and leaves the direction unchanged.
  always_comb begin
    last_dir_n = last_dir;
    if (bus.up_signal && !bus.down_signal)      last_dir_n = DIR_UP;
    else if (bus.down_signal && !bus.up_signal) last_dir_n = DIR_DOWN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_dir  <= DIR_IDLE;
      pend_in_q <= '0;
      pend_up_q <= '0;
      pend_dn_q <= '0;
      new_req_q <= 1'b0;
    end else begin
      last_dir  <= last_dir_n;
      // Clear wins over a same-cycle set: the open door serves the press.
      pend_in_q <= (pend_in_q | in_rise) & ~fhot;
      pend_up_q <= (pend_up_q | up_rise) & ~clr_up;
      pend_dn_q <= (pend_dn_q | dn_rise) & ~clr_dn;
      new_req_q <= (|(in_rise & ~pend_in_q & ~fhot)) |
                   (|(up_rise & ~pend_up_q & ~clr_up)) |
                   (|(dn_rise & ~pend_dn_q & ~clr_dn));
    end
  end

  assign bus.pend_in   = pend_in_q;
  assign bus.pend_up   = pend_up_q;
  assign bus.pend_down = pend_dn_q;
  assign bus.requests  = req;
  assign bus.req_above = has_above;
  assign bus.req_below = has_below;
  assign bus.req_here  = in_range & req[floor_sat];
  assign bus.new_req   = new_req_q;

endmodule

// File: tb/tb_elev_request_queue.sv
// Self-checking bench for elev_request_queue: expected pending state is queued
// when a press is driven and compared when new_req pulses.
module tb_elev_request_queue;

  localparam int NF = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  elev_request_queue_if #(.N_FLOORS(NF), .FLOOR_W(4)) bus();

  elev_request_queue #(.N_FLOORS(NF), .FLOOR_W(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [NF-1:0] pin;
    logic [NF-2:0] pup;
    logic [NF-1:1] pdn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.buttons_inside       = '0;
    bus.buttons_outside_up   = '0;
    bus.buttons_outside_down = '0;
    bus.floor                = '0;
    bus.open_door            = 1'b0;
    bus.up_signal            = 1'b0;
    bus.down_signal          = 1'b0;
  endtask

  // Scoreboard consumer: wait for new_req, then check pending state against the head entry.
  task automatic wait_req(input string name, input int budget, output int lat);
    exp_t e;
    lat = 0;
    while (bus.new_req !== 1'b1 && lat < budget) begin
      step(1);
      lat++;
    end
    checks++;
    if (bus.new_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: new_req got %b want 1 within %0d cycles", name, bus.new_req, budget);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: new_req got 1 with no expected entry", name);
    end else begin
      e = exp_q.pop_front();
      if ({bus.pend_in, bus.pend_up, bus.pend_down} !== {e.pin, e.pup, e.pdn}) begin
        errors++;
        $display("FAIL %s: pend in/up/dn got %b/%b/%b want %b/%b/%b", name,
                 bus.pend_in, bus.pend_up, bus.pend_down, e.pin, e.pup, e.pdn);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(2);
    checks++;
    if ({bus.pend_in, bus.pend_up, bus.pend_down, bus.requests, bus.req_above,
         bus.req_below, bus.req_here, bus.new_req} !== '0) begin
      errors++;
      $display("FAIL reset_state: got in=%b up=%b dn=%b req=%b nr=%b want all 0",
               bus.pend_in, bus.pend_up, bus.pend_down, bus.requests, bus.new_req);
    end
    #2 reset = 1'b0;
    step(5);
  endtask

  task automatic test_cabin_press();
    int lat;
    bus.floor = 4'd0;
    bus.buttons_inside = 10'b0000010000;
    exp_q.push_back('{10'b0000010000, 9'b0, 9'b0});
    step(1);
    bus.buttons_inside = '0;
    checks++;
    if (bus.pend_in !== 10'b0) begin
      errors++;
      $display("FAIL cabin_early: pend_in got %b want 0", bus.pend_in);
    end
    wait_req("cabin_press", 10, lat);
    checks++;
    if (lat + 1 !== 3) begin
      errors++;
      $display("FAIL cabin_latency: edges got %0d want 3", lat + 1);
    end
    checks++;
    if (bus.requests !== 10'b0000010000 || {bus.req_above, bus.req_below, bus.req_here} !== 3'b100) begin
      errors++;
      $display("FAIL cabin_summary: req=%b abh=%b want 0000010000 100", bus.requests,
               {bus.req_above, bus.req_below, bus.req_here});
    end
    step(1);
    checks++;
    if (bus.new_req !== 1'b0) begin
      errors++;
      $display("FAIL cabin_pulse_width: new_req got %b want 0", bus.new_req);
    end
  endtask

  task automatic test_hold_up();
    int lat;
    int pulses = 0;
    bus.buttons_outside_up = 9'b000001000;
    exp_q.push_back('{10'b0000010000, 9'b000001000, 9'b0});
    wait_req("hold_up", 10, lat);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.new_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL hold_single_event: extra pulses got %0d want 0", pulses);
    end
    bus.buttons_outside_up = '0;
    bus.floor = 4'd3;
    bus.open_door = 1'b1;
    step(1);
    bus.open_door = 1'b0;
    checks++;
    if (bus.pend_up !== 9'b0 || bus.pend_in !== 10'b0000010000) begin
      errors++;
      $display("FAIL idle_clear: up=%b in=%b want 000000000 0000010000", bus.pend_up, bus.pend_in);
    end
  endtask

  task automatic test_collective();
    int lat;
    logic [NF-1:1] dn5;
    dn5 = '0;
    dn5[5] = 1'b1;
    bus.floor = 4'd4;
    bus.open_door = 1'b1;
    step(1);
    bus.open_door = 1'b0;
    checks++;
    if (bus.requests !== 10'b0) begin
      errors++;
      $display("FAIL floor4_served: requests got %b want 0", bus.requests);
    end
    bus.buttons_inside = 10'b0010000000;
    bus.buttons_outside_up = 9'b000100000;
    bus.buttons_outside_down = dn5;
    exp_q.push_back('{10'b0010000000, 9'b000100000, dn5});
    step(1);
    idle_inputs();
    bus.floor = 4'd4;
    wait_req("collective_set", 10, lat);
    bus.up_signal = 1'b1;
    step(1);
    bus.up_signal = 1'b0;
    bus.floor = 4'd5;
    bus.open_door = 1'b1;
    step(1);
    bus.open_door = 1'b0;
    checks++;
    if (bus.pend_up !== 9'b0 || bus.pend_down !== dn5 || bus.pend_in !== 10'b0010000000) begin
      errors++;
      $display("FAIL up_keeps_down: up=%b dn=%b in=%b want 0 %b 0010000000",
               bus.pend_up, bus.pend_down, bus.pend_in, dn5);
    end
    bus.floor = 4'd7;
    bus.open_door = 1'b1;
    step(1);
    bus.open_door = 1'b0;
    bus.floor = 4'd5;
    bus.open_door = 1'b1;
    step(1);
    bus.open_door = 1'b0;
    checks++;
    if (bus.requests !== 10'b0) begin
      errors++;
      $display("FAIL up_clears_down: requests got %b want 0", bus.requests);
    end
    // Downward travel: up[2] must survive while in[0] is still below.
    bus.buttons_inside = 10'b0000000001;
    bus.buttons_outside_up = 9'b000000100;
    exp_q.push_back('{10'b0000000001, 9'b000000100, 9'b0});
    step(1);
    idle_inputs();
    bus.floor = 4'd5;
    wait_req("down_set", 10, lat);
    bus.down_signal = 1'b1;
    step(1);
    bus.up_signal = 1'b1;  // illegal: direction must stay DOWN
    step(1);
    bus.up_signal = 1'b0;
    bus.down_signal = 1'b0;
    bus.floor = 4'd2;
    bus.open_door = 1'b1;
    step(1);
    bus.open_door = 1'b0;
    checks++;
    if (bus.pend_up !== 9'b000000100 || bus.pend_in !== 10'b0000000001) begin
      errors++;
      $display("FAIL down_keeps_up: up=%b in=%b want 000000100 0000000001", bus.pend_up, bus.pend_in);
    end
    bus.floor = 4'd0;
    bus.open_door = 1'b1;
    step(1);
    bus.floor = 4'd2;
    step(1);
    bus.open_door = 1'b0;
    checks++;
    if (bus.requests !== 10'b0) begin
      errors++;
      $display("FAIL down_clears_up: requests got %b want 0", bus.requests);
    end
  endtask

  task automatic test_served_press();
    int bad = 0;
    bus.floor = 4'd6;
    bus.open_door = 1'b1;
    bus.buttons_inside = 10'b0001000000;
    step(1);
    bus.buttons_inside = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.pend_in[6] !== 1'b0 || bus.new_req !== 1'b0) bad++;
    end
    bus.open_door = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL served_press: cycles with set/new_req got %0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.buttons_inside = 10'b0100000100;
    exp_q.push_back('{10'b0100000100, 9'b0, 9'b0});
    step(1);
    bus.buttons_inside = '0;
    wait_req("reset_mid_set", 10, lat);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({bus.pend_in, bus.requests, bus.req_above, bus.req_below, bus.new_req} !== '0) begin
      errors++;
      $display("FAIL async_reset: in=%b req=%b nr=%b want 0", bus.pend_in, bus.requests, bus.new_req);
    end
    #2 reset = 1'b0;
    step(1);
    checks++;
    if ({bus.pend_in, bus.pend_up, bus.pend_down, bus.new_req} !== '0) begin
      errors++;
      $display("FAIL after_reset: in=%b nr=%b want 0", bus.pend_in, bus.new_req);
    end
    step(4);
  endtask

  task automatic test_held_through_reset();
    int lat;
    int bad = 0;
    bus.floor = 4'd5;
    bus.buttons_inside = 10'b0000000010;
    reset = 1'b1;
    step(2);
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.new_req !== 1'b0 || bus.pend_in !== 10'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL held_through_reset: cycles with set got %0d want 0", bad);
    end
    bus.buttons_inside = '0;
    step(3);
    bus.buttons_inside = 10'b0000000010;
    exp_q.push_back('{10'b0000000010, 9'b0, 9'b0});
    step(1);
    bus.buttons_inside = '0;
    wait_req("repress_after_reset", 10, lat);
  endtask

  task automatic test_out_of_range();
    int lat;
    bus.buttons_inside = '1;
    exp_q.push_back('{10'b1111111111, 9'b0, 9'b0});
    step(1);
    bus.buttons_inside = '0;
    wait_req("fill_all", 10, lat);
    bus.floor = 4'd12;
    bus.open_door = 1'b1;
    step(2);
    checks++;
    if (bus.pend_in !== 10'b1111111111 ||
        {bus.req_above, bus.req_below, bus.req_here} !== 3'b010) begin
      errors++;
      $display("FAIL out_of_range: in=%b abh=%b want 1111111111 010", bus.pend_in,
               {bus.req_above, bus.req_below, bus.req_here});
    end
    bus.open_door = 1'b0;
    bus.floor = 4'd9;
    #1;
    checks++;
    if (bus.req_here !== 1'b1) begin
      errors++;
      $display("FAIL top_here: req_here got %b want 1", bus.req_here);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cabin_press();
    test_hold_up();
    test_collective();
    test_served_press();
    test_reset_mid();
    test_held_through_reset();
    test_out_of_range();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
